// File: rtl/terminal_pkg.sv
// Shared register map for the terminal receive port: window offsets,
// STATUS/CTRL bit positions, the value returned by unmapped reads, and a
// helper that assembles the STATUS word.
package terminal_pkg;

  localparam logic [7:0]  OFS_DATA   = 8'h00;
  localparam logic [7:0]  OFS_STATUS = 8'h04;
  localparam logic [7:0]  OFS_CTRL   = 8'h08;

  localparam int STATUS_NE_BIT    = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;

  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;
  localparam int CTRL_IEN_BIT     = 2;

  localparam logic [31:0] UNMAPPED_READ = 32'hFFFF_FFFF;

  // Pack the STATUS register; all bits not named here read as zero.
  function automatic logic [31:0] build_status(input logic ne, input logic full,
                                               input logic ovf, input logic [7:0] cnt);
    logic [31:0] word;
    word = '0;
    word[STATUS_NE_BIT]   = ne;
    word[STATUS_FULL_BIT] = full;
    word[STATUS_OVF_BIT]  = ovf;
    word[STATUS_COUNT_LSB +: 8] = cnt;
    return word;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO. The head is shown combinationally on dout
// (8'h00 when empty); a push into an empty FIFO becomes visible one cycle
// later. Flush overrides any same-cycle push or pop.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  // Storage array; writes dropped by a flush are harmless since the pointers reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/terminal_rx.sv
// Memory-mapped terminal input port. Bytes arrive over in_valid/in_ready
// into a byte_fifo; the CPU polls STATUS and pops DATA through a 256-byte
// window at addr[31:8] == BASE_PAGE.
// Optional build macro: TERMINAL_RX_IRQ_EN adds a registered irq output.
module terminal_rx
  import terminal_pkg::*;
#(
  parameter logic [23:0] BASE_PAGE = 24'h000001,
  parameter int          DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] data_write,
  output logic [31:0] data_read,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready
`ifdef TERMINAL_RX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic          sel;
  logic [7:0]    offset;
  logic          ctrl_write;
  logic          flush;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          ovf;
  logic          ien;
  logic          unused_write_bits;

  assign sel        = (addr[31:8] == BASE_PAGE);
  assign offset     = addr[7:0];
  assign ctrl_write = sel && we && (offset == OFS_CTRL);
  assign flush      = ctrl_write && data_write[CTRL_FLUSH_BIT];
  assign push       = in_valid && !full;
  assign pop        = sel && re && (offset == OFS_DATA) && !empty;
  assign in_ready   = !full;

  assign unused_write_bits = ^data_write[31:3];

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (in_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Sticky overflow flag and interrupt enable; a new overflow beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
      ien <= 1'b0;
    end else begin
      if (in_valid && full) begin
        ovf <= 1'b1;
      end else if (ctrl_write && data_write[CTRL_CLR_OVF_BIT]) begin
        ovf <= 1'b0;
      end
      if (ctrl_write) begin
        ien <= data_write[CTRL_IEN_BIT];
      end
    end
  end

`ifdef TERMINAL_RX_IRQ_EN
  // Registered interrupt: asserted while enabled and data is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= ien && !empty;
    end
  end
`endif

  // Read mux; DATA shows the head in the same cycle the pop is requested.
  always_comb begin
    data_read = UNMAPPED_READ;
    if (sel) begin
      case (offset)
        OFS_DATA:   data_read = {23'h0, !empty, head};
        OFS_STATUS: data_read = build_status(!empty, full, ovf, 8'(count));
        OFS_CTRL:   data_read = {29'h0, ien, 2'b00};
        default:    data_read = UNMAPPED_READ;
      endcase
    end
  end

endmodule

// File: tb/tb_terminal_rx.sv
// Self-checking bench for terminal_rx: a directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_terminal_rx;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        we;
  logic        re;
  logic [31:0] addr;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
`ifdef TERMINAL_RX_IRQ_EN
  logic        irq;
`endif

  int tests_run;
  int tests_failed;

  terminal_rx #(
    .BASE_PAGE(24'h000001),
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .re         (re),
    .addr       (addr),
    .data_write (data_write),
    .data_read  (data_read),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready)
`ifdef TERMINAL_RX_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] dw;
    logic        iv;
    logic [7:0]  id;
    logic [31:0] exp_rd;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: the FIFO is just a queue of bytes.
  logic [7:0] m_q[$];
  logic       m_ovf;
  logic       m_ien;
  logic       m_irq;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] a,
                               input logic [31:0] dw, input logic iv, input logic [7:0] id);
    we         = w;
    re         = r;
    addr       = a;
    data_write = dw;
    in_valid   = iv;
    in_data    = id;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic doReset();
    idle();
    reset = 1'b1;
    #2;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic pushByte(input logic [7:0] b);
    applyStimulus(1'b0, 1'b0, 32'h0000_0104, 32'h0, 1'b1, b);
    tick();
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    int n;
    n = m_q.size();
    if (a[31:8] != 24'h000001) return 32'hFFFF_FFFF;
    case (a[7:0])
      8'h00:   return (n > 0) ? {23'h0, 1'b1, m_q[0]} : 32'h0;
      8'h04:   return {16'h0, 8'(n), 5'h0, m_ovf, (n == DEPTH), (n > 0)};
      8'h08:   return {29'h0, m_ien, 2'b00};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    idle();
    doReset();

    // Directed table: expectations are the values visible before the edge.
    vecs.push_back(vec_t'{0, 0, 32'h0000_0104, 32'h0, 0, 8'h00, 32'h0000_0000, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0000_0100, 32'h0, 0, 8'h00, 32'h0000_0000, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0000_0110, 32'h0, 0, 8'h00, 32'hFFFF_FFFF, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0000_0004, 32'h0, 0, 8'h00, 32'hFFFF_FFFF, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0000_0104, 32'h0, 1, 8'h41, 32'h0000_0000, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0000_0104, 32'h0, 1, 8'h42, 32'h0000_0101, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0000_0104, 32'h0, 0, 8'h00, 32'h0000_0201, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0000_0100, 32'h0, 0, 8'h00, 32'h0000_0141, 1});
    vecs.push_back(vec_t'{0, 1, 32'h0000_0100, 32'h0, 0, 8'h00, 32'h0000_0141, 1});
    vecs.push_back(vec_t'{0, 1, 32'h0000_0100, 32'h0, 0, 8'h00, 32'h0000_0142, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0000_0104, 32'h0, 0, 8'h00, 32'h0000_0000, 1});
    vecs.push_back(vec_t'{0, 1, 32'h0000_0100, 32'h0, 0, 8'h00, 32'h0000_0000, 1});
    vecs.push_back(vec_t'{1, 0, 32'h0000_0108, 32'h4, 0, 8'h00, 32'h0000_0000, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0000_0108, 32'h0, 0, 8'h00, 32'h0000_0004, 1});
    vecs.push_back(vec_t'{1, 0, 32'h0000_010C, 32'h0, 0, 8'h00, 32'hFFFF_FFFF, 1});
    vecs.push_back(vec_t'{1, 0, 32'h0000_0108, 32'h0, 0, 8'h00, 32'h0000_0004, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0000_0108, 32'h0, 0, 8'h00, 32'h0000_0000, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].dw, vecs[i].iv, vecs[i].id);
      checkOutput($sformatf("vec%0d_read", i), data_read, vecs[i].exp_rd);
      checkOutput($sformatf("vec%0d_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].exp_ready});
      tick();
    end

    // Overflow: 17 pushes into 16 entries, then clear the sticky flag.
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0000_0104, 32'h0, 1'b1, 8'(i));
      checkOutput($sformatf("ovf_ready%0d", i), {31'h0, in_ready}, (i < 16) ? 32'h1 : 32'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'h0000_0104, 32'h0, 1'b0, 8'h00);
    checkOutput("ovf_status", data_read, 32'h0000_1007);
    applyStimulus(1'b1, 1'b0, 32'h0000_0108, 32'h2, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0000_0104, 32'h0, 1'b0, 8'h00);
    checkOutput("ovf_cleared", data_read, 32'h0000_1003);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b0, 8'h00);
      checkOutput($sformatf("ovf_drain%0d", i), data_read, 32'h100 | 32'(i));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'h0000_0104, 32'h0, 1'b0, 8'h00);
    checkOutput("ovf_empty", data_read, 32'h0000_0000);

    // Simultaneous push and pop keeps count and order.
    doReset();
    pushByte(8'h01);
    pushByte(8'h02);
    pushByte(8'h03);
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b1, 8'h55);
    checkOutput("pp_head", data_read, 32'h0000_0101);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0000_0104, 32'h0, 1'b0, 8'h00);
    checkOutput("pp_status", data_read, 32'h0000_0301);
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b0, 8'h00);
    checkOutput("pp_pop1", data_read, 32'h0000_0102);
    tick();
    checkOutput("pp_pop2", data_read, 32'h0000_0103);
    tick();
    checkOutput("pp_pop3", data_read, 32'h0000_0155);
    tick();
    checkOutput("pp_pop_empty", data_read, 32'h0000_0000);

    // Flush beats a same-cycle push.
    doReset();
    for (int i = 0; i < 5; i++) pushByte(8'h10 + 8'(i));
    applyStimulus(1'b1, 1'b0, 32'h0000_0108, 32'h1, 1'b1, 8'h99);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0000_0104, 32'h0, 1'b0, 8'h00);
    checkOutput("flush_status", data_read, 32'h0000_0000);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 8'h00);
    checkOutput("flush_data", data_read, 32'h0000_0000);

`ifdef TERMINAL_RX_IRQ_EN
    // Interrupt timing around a push and a pop.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0000_0108, 32'h4, 1'b0, 8'h00);
    tick();
    pushByte(8'h30);
    idle();
    checkOutput("irq_land", {31'h0, irq}, 32'h0);
    tick();
    checkOutput("irq_set", {31'h0, irq}, 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b0, 8'h00);
    tick();
    idle();
    checkOutput("irq_pop_edge", {31'h0, irq}, 32'h1);
    tick();
    checkOutput("irq_clear", {31'h0, irq}, 32'h0);
    pushByte(8'h31);
    pushByte(8'h32);
    idle();
    checkOutput("irq_again", {31'h0, irq}, 32'h1);
`else
    pushByte(8'h31);
    pushByte(8'h32);
    idle();
`endif

    // Asynchronous reset mid-stream takes effect without waiting for a clock.
    applyStimulus(1'b0, 1'b0, 32'h0000_0104, 32'h0, 1'b1, 8'h77);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("areset_status", data_read, 32'h0000_0000);
    checkOutput("areset_ready", {31'h0, in_ready}, 32'h1);
`ifdef TERMINAL_RX_IRQ_EN
    checkOutput("areset_irq", {31'h0, irq}, 32'h0);
`endif
    idle();
    tick();
    reset = 1'b0;
    #1;

    // Randomized traffic against the queue model.
    doReset();
    m_q.delete();
    m_ovf = 1'b0;
    m_ien = 1'b0;
    m_irq = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r_we;
      logic        r_re;
      logic        r_iv;
      logic [31:0] r_addr;
      logic [31:0] r_dw;
      logic [7:0]  r_id;
      logic        sel_ctrl;
      logic        do_pop;
      logic        irq_next;
      case ($urandom_range(0, 5))
        0:       r_addr = 32'h0000_0100;
        1:       r_addr = 32'h0000_0104;
        2:       r_addr = 32'h0000_0108;
        3:       r_addr = 32'h0000_0100;
        4:       r_addr = 32'h0000_0204;
        default: r_addr = $urandom;
      endcase
      r_we = ($urandom_range(0, 11) == 0);
      r_re = ($urandom_range(0, 1) == 1);
      r_iv = ($urandom_range(0, 9) < 6);
      r_id = 8'($urandom);
      r_dw = $urandom;
      if ($urandom_range(0, 3) != 0) r_dw[0] = 1'b0;
      applyStimulus(r_we, r_re, r_addr, r_dw, r_iv, r_id);

      checkOutput($sformatf("rnd%0d_read", cyc), data_read, modelRead(r_addr));
      checkOutput($sformatf("rnd%0d_ready", cyc), {31'h0, in_ready},
                  {31'h0, (m_q.size() < DEPTH)});
`ifdef TERMINAL_RX_IRQ_EN
      checkOutput($sformatf("rnd%0d_irq", cyc), {31'h0, irq}, {31'h0, m_irq});
`endif

      sel_ctrl = r_we && (r_addr == 32'h0000_0108);
      do_pop   = r_re && (r_addr == 32'h0000_0100) && (m_q.size() > 0);
      irq_next = m_ien && (m_q.size() > 0);
      if (r_iv && m_q.size() == DEPTH) m_ovf = 1'b1;
      else if (sel_ctrl && r_dw[1]) m_ovf = 1'b0;
      if (sel_ctrl) m_ien = r_dw[2];
      if (sel_ctrl && r_dw[0]) begin
        m_q.delete();
      end else begin
        logic can_push;
        can_push = (m_q.size() < DEPTH);
        if (do_pop) void'(m_q.pop_front());
        if (r_iv && can_push) m_q.push_back(r_id);
      end
      m_irq = irq_next;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/terminal_rx.md
Name: terminal_rx

Overview:
- Memory-mapped terminal input device: the receive-side counterpart of the existing terminal output port.
- Accepts bytes from an external keyboard/host source over a valid/ready handshake and buffers them in a FIFO.
- The CPU data-memory stage polls status and pops bytes through a 256-byte address window.
- Sits on the same data-bus decode as the terminal output port, in a separate window.

Parameters:
- BASE_PAGE, 24'h000001, match value for addr[31:8]; selects the device window.
- DEPTH, 16, FIFO entries; power of two, 2..128.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- we  in  1  CPU write strobe
- re  in  1  CPU read strobe; qualifies the pop side-effect
- addr  in  32  CPU byte address
- data_write  in  32  CPU write data
- data_read  out  32  CPU read data, combinational from addr
- in_data  in  8  byte from external source
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  FIFO can accept (= !full)
- irq  out  1  present only with TERMINAL_RX_IRQ_EN

Behaviour:
- Reset: asynchronous, active-high; clk is the only clock. Clears FIFO pointers and count, ovf, ien.
  - Outputs during/after reset: in_ready=1, irq=0; data_read follows the decode rules below.
- Select: sel = (addr[31:8]==BASE_PAGE). Offsets addr[7:0]:
  - 0x00 DATA (R): {23'h0, ne, byte}; ne = FIFO non-empty; byte = head entry, or 8'h00 when empty.
  - 0x04 STATUS (R): [0] non-empty, [1] full, [2] ovf (sticky), [15:8] count, others 0.
  - 0x08 CTRL (W): [0] flush, [1] clear ovf, [2] ien. Read returns {29'h0, ien, 2'b00}.
  - Any other offset, or !sel: data_read = 32'hFFFFFFFF. Writes to other offsets are ignored.
- Pop: sel & re & offset 0x00 & non-empty. Takes effect at posedge; data_read already showed the head that cycle, so read latency is 0.
  - Pop when empty: no-op.
- Push: in_valid & !full, at posedge.
  - in_valid & full: byte dropped, ovf set next edge.
  - in_ready is combinational = !full, using the current count only (no same-cycle pop credit).
- Simultaneous push+pop: count unchanged, both pointers advance. When the FIFO is empty, a push is visible on the following cycle only (no fall-through).
- Flush (CTRL[0]=1, sel & we): pointers and count go to 0 at posedge. Flush wins over a same-cycle push or pop; the pushed byte is discarded.
- Clear-ovf in the same cycle as a new overflow: set wins (ovf stays 1).
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, zero-extended into STATUS[15:8].
- we and re both active: write action and read side-effect each apply independently.

Optional Feature:
- Macro TERMINAL_RX_IRQ_EN.
- Defined: irq port exists; irq is registered = ien & non-empty, updated each posedge, reset 0.
- Not defined: no irq port; ien is still stored and readable, with no other effect.

Decomposition:
- Package terminal_pkg:
  - offset constants OFS_DATA=8'h00, OFS_STATUS=8'h04, OFS_CTRL=8'h08
  - STATUS/CTRL bit positions
  - UNMAPPED_READ=32'hFFFFFFFF
- Sub-module byte_fifo: synchronous single-clock FIFO, parameter DEPTH.
  - Ports: push, pop, flush, din, dout (head), full, empty, count.
  - terminal_rx owns decode, ovf, ien and irq.

Test Plan:
- After reset, read 0x04 -> 0x00000000; read 0x00 -> 0x00000000; read 0x10 -> 0xFFFFFFFF; in_ready=1.
- Push 0x41, 0x42 -> STATUS=0x00000201. Read DATA with re -> 0x00000141. Next read -> 0x00000142. Then STATUS=0x00000000.
- Push 17 bytes 0x00..0x10 with DEPTH=16 and no pops -> in_ready=0 after 16 pushes; STATUS=0x00001007; 0x10 dropped. Write CTRL=0x2 -> STATUS=0x00001003.
- FIFO holds 3 bytes; same-cycle push 0x55 and DATA pop -> count stays 3; pop order preserved; 0x55 returned last.
- FIFO holds 5 bytes; write CTRL=0x1 while in_valid=1 -> STATUS=0x00000000 next cycle; pushed byte absent.
- IRQ build: write CTRL=0x4, push 0x30 -> irq=1 on the cycle after the byte lands; pop -> irq=0 one cycle after the pop edge. Assert reset mid-stream -> irq=0 and FIFO empty immediately.
